// File: rtl/spi_pkg.sv
// Shared register map, CR1/SR bit positions, FSM encoding and bit-order helpers for the SPI slave.
package spi_pkg;

  localparam logic [2:0] ADDR_CR1 = 3'b000;
  localparam logic [2:0] ADDR_SR  = 3'b011;
  localparam logic [2:0] ADDR_DR  = 3'b101;

  localparam int CR1_SPIE  = 7;
  localparam int CR1_SPE   = 6;
  localparam int CR1_CPOL  = 3;
  localparam int CR1_CPHA  = 2;
  localparam int CR1_LSBFE = 0;
  localparam logic [7:0] CR1_MASK = 8'hCD;

  localparam int SR_SPIF  = 7;
  localparam int SR_SPTEF = 5;
  localparam int SR_OVRF  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } spi_state_e;

  // Bit presented on the line next, according to bit order.
  function automatic logic out_bit(input logic [7:0] d, input logic lsb_first);
    return lsb_first ? d[0] : d[7];
  endfunction

  function automatic logic [7:0] shift_tx(input logic [7:0] d, input logic lsb_first);
    return lsb_first ? {1'b0, d[7:1]} : {d[6:0], 1'b0};
  endfunction

  function automatic logic [7:0] shift_rx(input logic [7:0] d, input logic b, input logic lsb_first);
    return lsb_first ? {b, d[7:1]} : {d[6:0], b};
  endfunction

endpackage

// File: rtl/spi_slave_sync.sv
// Brings sclk/ss/mosi into the PCLK domain and turns sclk transitions into sample/shift strobes.
module spi_slave_sync
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sclk,
  input  logic ss,
  input  logic mosi,
  input  logic cpol,
  input  logic cpha,
  output logic ss_sync,
  output logic mosi_sync,
  output logic ss_fall,
  output logic sample_edge,
  output logic shift_edge
);

  logic [SYNC_STAGES-1:0] sclk_ff;
  logic [SYNC_STAGES-1:0] ss_ff;
  logic [SYNC_STAGES-1:0] mosi_ff;
  logic sclk_prev;
  logic ss_prev;
  logic sclk_sync;
  logic rise;
  logic fall;
  logic leading;
  logic trailing;

  if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_stage_check
    $error("spi_slave_sync: SYNC_STAGES must be 2 or 3");
  end

  // Synchronizer chains plus one history flop for edge detection; idle-high after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_ff   <= '1;
      ss_ff     <= '1;
      mosi_ff   <= '1;
      sclk_prev <= 1'b1;
      ss_prev   <= 1'b1;
    end else begin
      sclk_ff   <= {sclk_ff[SYNC_STAGES-2:0], sclk};
      ss_ff     <= {ss_ff[SYNC_STAGES-2:0], ss};
      mosi_ff   <= {mosi_ff[SYNC_STAGES-2:0], mosi};
      sclk_prev <= sclk_ff[SYNC_STAGES-1];
      ss_prev   <= ss_ff[SYNC_STAGES-1];
    end
  end

  assign sclk_sync   = sclk_ff[SYNC_STAGES-1];
  assign ss_sync     = ss_ff[SYNC_STAGES-1];
  assign mosi_sync   = mosi_ff[SYNC_STAGES-1];
  assign ss_fall     = ss_prev & ~ss_sync;
  assign rise        = sclk_sync & ~sclk_prev;
  assign fall        = ~sclk_sync & sclk_prev;
  assign leading     = cpol ? fall : rise;
  assign trailing    = cpol ? rise : fall;
  assign sample_edge = cpha ? trailing : leading;
  assign shift_edge  = cpha ? leading : trailing;

endmodule

// File: rtl/spi_slave.sv
// APB-programmed SPI slave. Define SPI_SLAVE_RXFIFO_EN to replace the single RX register with an RX FIFO.
module spi_slave
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int RX_FIFO_DEPTH = 4
) (
  input  logic       PCLK,
  input  logic       PRESET,
  input  logic [2:0] PADDR,
  input  logic       PWRITE,
  input  logic       PSEL,
  input  logic       PENABLE,
  input  logic [7:0] PWDATA,
  output logic [7:0] PRDATA,
  output logic       PREADY,
  output logic       PSLVERR,
  input  logic       sclk,
  input  logic       ss,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  output logic       spi_interrupt_request
);

  spi_state_e state;
  logic [7:0] cr1, tx_buf, tx_sr, rx_sr, rx_data, sr;
  logic [2:0] bit_cnt;
  logic       spif, ovrf, sptef, miso_bit;
  logic       ss_sync, mosi_sync, ss_fall, sample_edge, shift_edge;
  logic       spie, spe, cpol, cpha, lsbfe;
  logic       access, wr_cr1, wr_dr, rd_dr, bad_access, frame_start, push;
  logic [7:0] load_data;

  if (RX_FIFO_DEPTH < 2 || (RX_FIFO_DEPTH & (RX_FIFO_DEPTH - 1)) != 0) begin : g_depth_check
    $error("spi_slave: RX_FIFO_DEPTH must be a power of 2, at least 2");
  end

  assign spie  = cr1[CR1_SPIE];
  assign spe   = cr1[CR1_SPE];
  assign cpol  = cr1[CR1_CPOL];
  assign cpha  = cr1[CR1_CPHA];
  assign lsbfe = cr1[CR1_LSBFE];

  assign access     = PSEL & PENABLE;
  assign wr_cr1     = access & PWRITE & (PADDR == ADDR_CR1);
  assign wr_dr      = access & PWRITE & (PADDR == ADDR_DR);
  assign rd_dr      = access & ~PWRITE & (PADDR == ADDR_DR);
  assign bad_access = access & (((PADDR != ADDR_CR1) && (PADDR != ADDR_SR) && (PADDR != ADDR_DR))
                                || (PWRITE && (PADDR == ADDR_SR)));
  assign PREADY     = 1'b1;

  // A frame starts on ss falling from idle, or back-to-back straight out of DONE.
  assign frame_start = spe & ~ss_sync & (((state == ST_IDLE) & ss_fall) | (state == ST_DONE));
  assign push        = (state == ST_DONE);
  assign load_data   = sptef ? 8'hFF : tx_buf;
  assign miso_oe     = (state != ST_IDLE) & ~ss_sync;
  assign miso        = miso_oe & miso_bit;

  spi_slave_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk(PCLK), .rst(PRESET), .sclk(sclk), .ss(ss), .mosi(mosi), .cpol(cpol), .cpha(cpha),
    .ss_sync(ss_sync), .mosi_sync(mosi_sync), .ss_fall(ss_fall),
    .sample_edge(sample_edge), .shift_edge(shift_edge)
  );

  // Control register, TX buffer and the TX-empty flag.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      cr1    <= 8'h00;
      tx_buf <= 8'h00;
      sptef  <= 1'b1;
    end else begin
      if (wr_cr1) cr1 <= PWDATA & CR1_MASK;
      if (wr_dr) tx_buf <= PWDATA;
      if (wr_dr) sptef <= 1'b0;
      else if (frame_start) sptef <= 1'b1;
    end
  end

  // Frame FSM: with cpha=0 the first bit is pre-shifted so it is on miso before the first edge.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state    <= ST_IDLE;
      bit_cnt  <= 3'd0;
      tx_sr    <= 8'h00;
      rx_sr    <= 8'h00;
      miso_bit <= 1'b0;
    end else if (!spe) begin
      state    <= ST_IDLE;
      bit_cnt  <= 3'd0;
      miso_bit <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (frame_start) begin
            state   <= ST_SHIFT;
            bit_cnt <= 3'd0;
            if (!cpha) begin
              miso_bit <= out_bit(load_data, lsbfe);
              tx_sr    <= shift_tx(load_data, lsbfe);
            end else begin
              miso_bit <= 1'b0;
              tx_sr    <= load_data;
            end
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          if (ss_sync) begin
            state   <= ST_IDLE;
            bit_cnt <= 3'd0;
          end else begin
            if (shift_edge) begin
              miso_bit <= out_bit(tx_sr, lsbfe);
              tx_sr    <= shift_tx(tx_sr, lsbfe);
            end
            if (sample_edge) begin
              rx_sr   <= shift_rx(rx_sr, mosi_sync, lsbfe);
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) state <= ST_DONE;
            end
          end
        end
        default: begin
          state   <= ST_IDLE;
          bit_cnt <= 3'd0;
        end
      endcase
    end
  end

`ifdef SPI_SLAVE_RXFIFO_EN
  localparam int AW = $clog2(RX_FIFO_DEPTH);
  logic [7:0]  fifo_mem [RX_FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        empty, full, pop, do_push;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign pop     = rd_dr & ~empty;
  assign do_push = push & (~full | pop);
  assign spif    = ~empty;
  assign rx_data = empty ? 8'h00 : fifo_mem[rd_ptr[AW-1:0]];

  // RX FIFO; a push into a full FIFO only succeeds when a pop happens in the same cycle.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovrf   <= 1'b0;
    end else begin
      if (do_push) begin
        fifo_mem[wr_ptr[AW-1:0]] <= rx_sr;
        wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      end
      if (pop) rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
      if (push && !do_push) ovrf <= 1'b1;
      else if (rd_dr) ovrf <= 1'b0;
    end
  end
`else
  // Single RX register; an unread byte is kept and the newer one dropped.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      rx_data <= 8'h00;
      spif    <= 1'b0;
      ovrf    <= 1'b0;
    end else if (push) begin
      if (spif && !rd_dr) begin
        ovrf <= 1'b1;
      end else begin
        rx_data <= rx_sr;
        spif    <= 1'b1;
        if (rd_dr) ovrf <= 1'b0;
      end
    end else if (rd_dr) begin
      spif <= 1'b0;
      ovrf <= 1'b0;
    end
  end
`endif

  always_comb begin
    sr = 8'h00;
    sr[SR_SPIF]  = spif;
    sr[SR_SPTEF] = sptef;
    sr[SR_OVRF]  = ovrf;
  end

  // Read data is presented combinationally in the access phase so a DR read sees the byte it pops.
  always_comb begin
    PRDATA  = 8'h00;
    PSLVERR = 1'b0;
    if (access && !PRESET) begin
      PSLVERR = bad_access;
      if (!PWRITE) begin
        case (PADDR)
          ADDR_CR1: PRDATA = cr1;
          ADDR_SR:  PRDATA = sr;
          ADDR_DR:  PRDATA = rx_data;
          default:  PRDATA = 8'h00;
        endcase
      end else begin
        PRDATA = 8'h00;
      end
    end else begin
      PSLVERR = 1'b0;
    end
  end

  // Registered interrupt request.
  always_ff @(posedge PCLK) begin
    if (PRESET) spi_interrupt_request <= 1'b0;
    else spi_interrupt_request <= spie & spe & (spif | ovrf | sptef);
  end

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: APB register table plus directed SPI frames with scoreboard queues.
module tb_spi_slave;

  localparam int HALF = 40;  // sclk half period = 4 PCLK periods

  logic       PCLK = 1'b0;
  logic       PRESET = 1'b1;
  logic [2:0] PADDR = 3'b000;
  logic       PWRITE = 1'b0, PSEL = 1'b0, PENABLE = 1'b0;
  logic [7:0] PWDATA = 8'h00;
  logic [7:0] PRDATA;
  logic       PREADY, PSLVERR;
  logic       sclk = 1'b0, ss = 1'b1, mosi = 1'b1;
  logic       miso, miso_oe, spi_interrupt_request;

  int n_checks = 0;
  int n_fail = 0;
  logic [7:0] exp_miso_q[$];
  logic [7:0] exp_rx_q[$];

  typedef struct {
    logic       wr;
    logic [2:0] addr;
    logic [7:0] wdata;
    logic       chk_data;
    logic [7:0] exp_data;
    logic       exp_err;
  } apb_vec_t;

  spi_slave dut (
    .PCLK(PCLK), .PRESET(PRESET), .PADDR(PADDR), .PWRITE(PWRITE), .PSEL(PSEL),
    .PENABLE(PENABLE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR), .sclk(sclk), .ss(ss), .mosi(mosi), .miso(miso),
    .miso_oe(miso_oe), .spi_interrupt_request(spi_interrupt_request)
  );

  always #5 PCLK = ~PCLK;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic apb(input logic wr, input logic [2:0] addr, input logic [7:0] wdata,
                     output logic [7:0] rdata, output logic err);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    #3;
    rdata = PRDATA;
    err = PSLVERR;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic wr_reg(input logic [2:0] addr, input logic [7:0] d);
    logic [7:0] rd;
    logic err;
    apb(1'b1, addr, d, rd, err);
  endtask

  task automatic rd_check(input string name, input logic [2:0] addr, input logic [7:0] exp);
    logic [7:0] rd;
    logic err;
    apb(1'b0, addr, 8'h00, rd, err);
    check(name, rd, exp);
  endtask

  task automatic rd_dr_sb(input string name);
    logic [7:0] rd;
    logic err;
    apb(1'b0, 3'b101, 8'h00, rd, err);
    if (exp_rx_q.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL %s: got %02h expected nothing queued", name, rd);
    end else begin
      check(name, rd, exp_rx_q.pop_front());
    end
  endtask

  // SPI master: drives a frame of nbits and collects miso into bit positions by bit order.
  task automatic spi_xfer(input logic [7:0] tx, input logic pol, input logic pha, input logic lsb,
                          input int nbits, output logic [7:0] got, output logic oe_seen);
    got = 8'h00;
    oe_seen = 1'b1;
    ss = 1'b1; sclk = pol;
    #(HALF);
    ss = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      int idx;
      idx = lsb ? i : 7 - i;
      if (!pha) begin
        mosi = tx[idx];
        #(HALF); sclk = ~pol;
        got[idx] = miso; oe_seen = oe_seen & miso_oe;
        #(HALF); sclk = pol;
      end else begin
        #(HALF); sclk = ~pol; mosi = tx[idx];
        #(HALF); sclk = pol;
        got[idx] = miso; oe_seen = oe_seen & miso_oe;
      end
    end
    #(HALF); ss = 1'b1;
    #(HALF);
  endtask

  task automatic frame_sb(input string name, input logic [7:0] tx, input logic pol,
                          input logic pha, input logic lsb);
    logic [7:0] got;
    logic oe;
    spi_xfer(tx, pol, pha, lsb, 8, got, oe);
    check({name, "_oe"}, {7'd0, oe}, 8'h01);
    if (exp_miso_q.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL %s_miso: got %02h expected nothing queued", name, got);
    end else begin
      check({name, "_miso"}, got, exp_miso_q.pop_front());
    end
    repeat (4) @(posedge PCLK);
    #1;
  endtask

  initial begin
    apb_vec_t vec[11];
    logic [7:0] rd, got;
    logic err, oe;

    vec[0]  = '{1'b0, 3'b000, 8'h00, 1'b1, 8'h00, 1'b0};
    vec[1]  = '{1'b0, 3'b011, 8'h00, 1'b1, 8'h20, 1'b0};
    vec[2]  = '{1'b0, 3'b101, 8'h00, 1'b1, 8'h00, 1'b0};
    vec[3]  = '{1'b1, 3'b000, 8'hFF, 1'b0, 8'h00, 1'b0};
    vec[4]  = '{1'b0, 3'b000, 8'h00, 1'b1, 8'hCD, 1'b0};
    vec[5]  = '{1'b1, 3'b011, 8'hFF, 1'b0, 8'h00, 1'b1};
    vec[6]  = '{1'b0, 3'b011, 8'h00, 1'b1, 8'h20, 1'b0};
    vec[7]  = '{1'b0, 3'b010, 8'h00, 1'b0, 8'h00, 1'b1};
    vec[8]  = '{1'b1, 3'b111, 8'h55, 1'b0, 8'h00, 1'b1};
    vec[9]  = '{1'b1, 3'b000, 8'h00, 1'b0, 8'h00, 1'b0};
    vec[10] = '{1'b0, 3'b000, 8'h00, 1'b1, 8'h00, 1'b0};

    // Reset state
    repeat (3) @(posedge PCLK);
    #1;
    check("rst_miso", {7'd0, miso}, 8'h00);
    check("rst_oe", {7'd0, miso_oe}, 8'h00);
    check("rst_irq", {7'd0, spi_interrupt_request}, 8'h00);
    check("rst_prdata", PRDATA, 8'h00);
    check("rst_pslverr", {7'd0, PSLVERR}, 8'h00);
    check("pready", {7'd0, PREADY}, 8'h01);
    PRESET = 1'b0;

    // Register map table
    for (int i = 0; i < 11; i++) begin
      apb(vec[i].wr, vec[i].addr, vec[i].wdata, rd, err);
      check($sformatf("apb%0d_err", i), {7'd0, err}, {7'd0, vec[i].exp_err});
      if (vec[i].chk_data) check($sformatf("apb%0d_data", i), rd, vec[i].exp_data);
    end
    @(posedge PCLK); #1;
    check("irq_off", {7'd0, spi_interrupt_request}, 8'h00);

    // Mode 0, LSB first
    wr_reg(3'b000, 8'hC1);
    wr_reg(3'b101, 8'hA5);
    exp_miso_q.push_back(8'hA5);
    exp_rx_q.push_back(8'h3C);
    frame_sb("m0", 8'h3C, 1'b0, 1'b0, 1'b1);
    check("m0_oe_after", {7'd0, miso_oe}, 8'h00);
    check("m0_irq", {7'd0, spi_interrupt_request}, 8'h01);
    rd_check("m0_sr", 3'b011, 8'hA0);
    rd_dr_sb("m0_dr");
    rd_check("m0_sr_clr", 3'b011, 8'h20);

    // Mode 3, MSB first
    wr_reg(3'b000, 8'hCC);
    wr_reg(3'b101, 8'hF0);
    exp_miso_q.push_back(8'hF0);
    exp_rx_q.push_back(8'h81);
    frame_sb("m3", 8'h81, 1'b1, 1'b1, 1'b0);
    rd_dr_sb("m3_dr");

    // Two frames with no read in between; TX buffer not rewritten so 0xFF goes out
    wr_reg(3'b000, 8'hC1);
    exp_miso_q.push_back(8'hFF);
    exp_miso_q.push_back(8'hFF);
    exp_rx_q.push_back(8'h11);
`ifdef SPI_SLAVE_RXFIFO_EN
    exp_rx_q.push_back(8'h22);
`endif
    frame_sb("f1", 8'h11, 1'b0, 1'b0, 1'b1);
    frame_sb("f2", 8'h22, 1'b0, 1'b0, 1'b1);
`ifdef SPI_SLAVE_RXFIFO_EN
    rd_check("ovr_sr", 3'b011, 8'hA0);
    rd_dr_sb("fifo_dr0");
    rd_dr_sb("fifo_dr1");
`else
    rd_check("ovr_sr", 3'b011, 8'hB0);
    rd_dr_sb("ovr_dr");
`endif
    rd_check("ovr_sr_clr", 3'b011, 8'h20);

    // ss raised after 4 bits, then a full frame
    spi_xfer(8'hF0, 1'b0, 1'b0, 1'b1, 4, got, oe);
    repeat (4) @(posedge PCLK);
    #1;
    check("part_oe", {7'd0, miso_oe}, 8'h00);
    check("part_miso", {7'd0, miso}, 8'h00);
    rd_check("part_sr", 3'b011, 8'h20);
    exp_miso_q.push_back(8'hFF);
    exp_rx_q.push_back(8'h55);
    frame_sb("full", 8'h55, 1'b0, 1'b0, 1'b1);
    rd_dr_sb("full_dr");

    // Reset in the middle of a frame
    wr_reg(3'b101, 8'h3C);
    sclk = 1'b0; ss = 1'b0;
    #(HALF); sclk = 1'b1;
    #(HALF); sclk = 1'b0;
    #(HALF);
    check("mid_oe", {7'd0, miso_oe}, 8'h01);
    @(posedge PCLK); #1;
    PRESET = 1'b1;
    @(posedge PCLK); #1;
    check("prst_miso", {7'd0, miso}, 8'h00);
    check("prst_oe", {7'd0, miso_oe}, 8'h00);
    check("prst_irq", {7'd0, spi_interrupt_request}, 8'h00);
    check("prst_prdata", PRDATA, 8'h00);
    check("prst_pslverr", {7'd0, PSLVERR}, 8'h00);
    PRESET = 1'b0;
    ss = 1'b1;
    repeat (4) @(posedge PCLK);
    rd_check("prst_sr", 3'b011, 8'h20);
    rd_check("prst_cr1", 3'b000, 8'h00);
    rd_check("prst_dr", 3'b101, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
